// File: rtl/instruction_fetch.sv
// instruction_fetch -- IF stage of the pipeline.
// Fetches one instruction per request/response handshake with the instruction
// memory and loads it into the IF/ID register. The hazard unit can freeze the
// stage, and ID can redirect the fetch stream with a branch or a jump.
//
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_stall                   freeze PC and IF/ID
//   i_branch_sel, i_jump_sel  redirect requests from ID (jump has priority)
//   i_branch_address          branch target
//   i_jump_address            jump target
//   o_imem_req, o_imem_addr   memory request and fetch address
//   i_imem_ready, i_imem_data memory response
//   o_instruc                 IF/ID instruction
//   o_current_PC              IF/ID fetch address + 1
//   o_if_valid                IF/ID holds a real instruction
//   o_fetch_count             delivered-instruction counter (IF_FETCH_COUNT_EN only)
//
// Build option: define IF_FETCH_COUNT_EN to add the 32-bit o_fetch_count port.

`ifndef PC_SIZE
`define PC_SIZE 9
`endif

module instruction_fetch #(
  parameter int          PC_W = `PC_SIZE + 1,
  parameter logic [31:0] NOP  = 32'h0000_0000
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_branch_sel,
  input  logic            i_jump_sel,
  input  logic [PC_W-1:0] i_branch_address,
  input  logic [PC_W-1:0] i_jump_address,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic [31:0]     i_imem_data,
  output logic [31:0]     o_instruc,
  output logic [PC_W-1:0] o_current_PC,
`ifdef IF_FETCH_COUNT_EN
  output logic [31:0]     o_fetch_count,
`endif
  output logic            o_if_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_fetchAddr;
  logic [PC_W-1:0] r_currentPc;
  logic [31:0]     r_instruc;
  logic [31:0]     r_buffer;
  logic            r_ifValid;
  logic            r_drop;
  logic            r_imemReq;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0]     r_fetchCount;
`endif

  logic            w_redirect;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_nextSeq;
  logic            w_deliver;
  logic [31:0]     w_deliverData;

  // A stall suppresses redirects: ID re-presents the branch once it is free.
  // Delivery comes either straight from memory or from the hold buffer.
  always_comb begin
    w_redirect    = (i_jump_sel | i_branch_sel) & ~i_stall;
    w_target      = i_jump_sel ? i_jump_address : i_branch_address;
    w_nextSeq     = r_fetchAddr + PC_W'(1);
    w_deliver     = 1'b0;
    w_deliverData = i_imem_data;
    if (r_state == S_WAIT && i_imem_ready && !r_drop && !i_stall && !w_redirect)
      w_deliver = 1'b1;
    if (r_state == S_HOLD && !i_stall && !w_redirect) begin
      w_deliver     = 1'b1;
      w_deliverData = r_buffer;
    end
  end

  // Fetch FSM plus IF/ID register. r_fetchAddr is always loaded with the
  // address of the next request before S_REQ is entered, so o_imem_addr is
  // stable for the whole S_REQ/S_WAIT window. On any cycle that is neither a
  // delivery nor a stall, IF/ID becomes a bubble so ID never sees the same
  // instruction twice.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_fetchAddr  <= '0;
      r_currentPc  <= '0;
      r_instruc    <= NOP;
      r_buffer     <= '0;
      r_ifValid    <= 1'b0;
      r_drop       <= 1'b0;
      r_imemReq    <= 1'b0;
`ifdef IF_FETCH_COUNT_EN
      r_fetchCount <= '0;
`endif
    end else begin
      if (w_deliver) begin
        r_instruc    <= w_deliverData;
        r_currentPc  <= w_nextSeq;
        r_ifValid    <= 1'b1;
        r_pc         <= w_nextSeq;
`ifdef IF_FETCH_COUNT_EN
        r_fetchCount <= r_fetchCount + 32'd1;
`endif
      end else if (w_redirect || !i_stall) begin
        r_instruc <= NOP;
        r_ifValid <= 1'b0;
        if (w_redirect)
          r_pc <= w_target;
      end

      case (r_state)
        S_IDLE: begin
          r_fetchAddr <= w_redirect ? w_target : r_pc;
          r_imemReq   <= 1'b1;
          r_state     <= S_REQ;
        end
        S_REQ: begin
          // A redirect here lets the issued request finish but marks it dropped.
          r_fetchAddr <= r_pc;
          r_drop      <= w_redirect;
          r_imemReq   <= 1'b1;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (i_imem_ready) begin
            r_drop <= 1'b0;
            if (w_redirect) begin
              r_fetchAddr <= w_target;
              r_state     <= S_REQ;
            end else if (r_drop) begin
              r_fetchAddr <= r_pc;
              r_state     <= S_REQ;
            end else if (i_stall) begin
              r_buffer  <= i_imem_data;
              r_imemReq <= 1'b0;
              r_state   <= S_HOLD;
            end else begin
              r_fetchAddr <= w_nextSeq;
              r_state     <= S_REQ;
            end
          end else if (w_redirect) begin
            r_drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            r_fetchAddr <= w_target;
            r_imemReq   <= 1'b1;
            r_state     <= S_REQ;
          end else if (!i_stall) begin
            r_fetchAddr <= w_nextSeq;
            r_imemReq   <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_imem_req   = r_imemReq;
  assign o_imem_addr  = r_fetchAddr;
  assign o_instruc    = r_instruc;
  assign o_current_PC = r_currentPc;
  assign o_if_valid   = r_ifValid;
`ifdef IF_FETCH_COUNT_EN
  assign o_fetch_count = r_fetchCount;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch -- directed bench for instruction_fetch.
// Inputs change on the falling edge; outputs are checked on the falling edge,
// half a cycle after the rising edge that updated them. NOP is overridden to a
// non-zero value so bubbles are distinguishable from instruction word 0.
// Build option: IF_FETCH_COUNT_EN also checks o_fetch_count.

module tb_instruction_fetch;

  localparam int          PC_W = 10;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clock = 1'b0;
  logic            reset;
  logic            stall;
  logic            branchSel;
  logic            jumpSel;
  logic [PC_W-1:0] branchAddress;
  logic [PC_W-1:0] jumpAddress;
  logic            imemReq;
  logic [PC_W-1:0] imemAddr;
  logic            imemReady;
  logic [31:0]     imemData;
  logic [31:0]     instruc;
  logic [PC_W-1:0] currentPc;
  logic            ifValid;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0]     fetchCount;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  instruction_fetch #(.PC_W(PC_W), .NOP(NOP)) dut (
    .i_clock          (clock),
    .i_reset          (reset),
    .i_stall          (stall),
    .i_branch_sel     (branchSel),
    .i_jump_sel       (jumpSel),
    .i_branch_address (branchAddress),
    .i_jump_address   (jumpAddress),
    .o_imem_req       (imemReq),
    .o_imem_addr      (imemAddr),
    .i_imem_ready     (imemReady),
    .i_imem_data      (imemData),
    .o_instruc        (instruc),
    .o_current_PC     (currentPc),
`ifdef IF_FETCH_COUNT_EN
    .o_fetch_count    (fetchCount),
`endif
    .o_if_valid       (ifValid)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, then advance to the next falling edge.
  task automatic applyStimulus(input logic st, input logic br, input logic jp,
                               input logic [PC_W-1:0] ba, input logic [PC_W-1:0] ja,
                               input logic rdy, input logic [31:0] d);
    stall         = st;
    branchSel     = br;
    jumpSel       = jp;
    branchAddress = ba;
    jumpAddress   = ja;
    imemReady     = rdy;
    imemData      = d;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; branchSel = 1'b0; jumpSel = 1'b0;
    branchAddress = '0; jumpAddress = '0; imemReady = 1'b0; imemData = '0;
    repeat (2) @(negedge clock);

    // Reset state
    checkOutput("rst_req",     32'(imemReq),   32'd0);
    checkOutput("rst_addr",    32'(imemAddr),  32'd0);
    checkOutput("rst_instruc", instruc,        NOP);
    checkOutput("rst_pc",      32'(currentPc), 32'd0);
    checkOutput("rst_valid",   32'(ifValid),   32'd0);
`ifdef IF_FETCH_COUNT_EN
    checkOutput("rst_count",   fetchCount,     32'd0);
`endif
    reset = 1'b0;

    // Sequential fetch with immediate ready, data = address
    applyStimulus(0, 0, 0, '0, '0, 1, 32'd0);
    checkOutput("seq_req",   32'(imemReq),  32'd1);
    checkOutput("seq_addr0", 32'(imemAddr), 32'd0);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'd0);
    checkOutput("seq_wait_valid", 32'(ifValid), 32'd0);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'd0);
    checkOutput("seq_instr0", instruc,        32'd0);
    checkOutput("seq_pc0",    32'(currentPc), 32'd1);
    checkOutput("seq_valid0", 32'(ifValid),   32'd1);
    checkOutput("seq_addr1",  32'(imemAddr),  32'd1);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'd1);
    checkOutput("seq_bubble_valid", 32'(ifValid), 32'd0);
    checkOutput("seq_bubble_instr", instruc,      NOP);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'd1);
    checkOutput("seq_instr1", instruc,        32'd1);
    checkOutput("seq_pc1",    32'(currentPc), 32'd2);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'd2);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'd2);
    checkOutput("seq_instr2", instruc,        32'd2);
    checkOutput("seq_pc2",    32'(currentPc), 32'd3);
    checkOutput("seq_valid2", 32'(ifValid),   32'd1);

    // Stall for three cycles with ready arriving during the stall
    applyStimulus(1, 0, 0, '0, '0, 1, 32'hA5A5_0003);
    checkOutput("stall_freeze_instr", instruc,      32'd2);
    checkOutput("stall_freeze_valid", 32'(ifValid), 32'd1);
    applyStimulus(1, 0, 0, '0, '0, 1, 32'hA5A5_0003);
    checkOutput("hold_req",   32'(imemReq),   32'd0);
    checkOutput("hold_instr", instruc,        32'd2);
    checkOutput("hold_pc",    32'(currentPc), 32'd3);
    applyStimulus(1, 0, 0, '0, '0, 1, 32'hFFFF_FFFF);
    checkOutput("hold2_instr", instruc, 32'd2);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'hFFFF_FFFF);
    checkOutput("unstall_instr", instruc,        32'hA5A5_0003);
    checkOutput("unstall_pc",    32'(currentPc), 32'd4);
    checkOutput("unstall_valid", 32'(ifValid),   32'd1);
    checkOutput("unstall_addr",  32'(imemAddr),  32'd4);
    checkOutput("unstall_req",   32'(imemReq),   32'd1);

    // Branch during S_WAIT, memory answers two cycles later
    applyStimulus(0, 0, 0, '0, '0, 0, 32'd4);
    applyStimulus(0, 1, 0, 10'h040, '0, 0, 32'd4);
    checkOutput("br_addr_stable", 32'(imemAddr), 32'd4);
    checkOutput("br_req",         32'(imemReq),  32'd1);
    checkOutput("br_valid",       32'(ifValid),  32'd0);
    checkOutput("br_instr",       instruc,       NOP);
    applyStimulus(0, 0, 0, '0, '0, 0, 32'd4);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h0000_0BAD);
    checkOutput("br_drop_addr",  32'(imemAddr),  32'h40);
    checkOutput("br_drop_instr", instruc,        NOP);
    checkOutput("br_drop_valid", 32'(ifValid),   32'd0);
    checkOutput("br_drop_pc",    32'(currentPc), 32'd4);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h40);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h40);
    checkOutput("br_target_instr", instruc,        32'h40);
    checkOutput("br_target_pc",    32'(currentPc), 32'h41);

    // Jump and branch together, same cycle as ready: jump wins, word dropped
    applyStimulus(0, 0, 0, '0, '0, 0, 32'd0);
    applyStimulus(0, 1, 1, 10'h020, 10'h010, 1, 32'h0000_DEAD);
    checkOutput("jb_addr",  32'(imemAddr),  32'h10);
    checkOutput("jb_valid", 32'(ifValid),   32'd0);
    checkOutput("jb_instr", instruc,        NOP);
    checkOutput("jb_pc",    32'(currentPc), 32'h41);

    // Jump to 0x3FF issued in S_REQ, then wrap of the sequential address
    applyStimulus(0, 0, 1, '0, 10'h3FF, 0, 32'd0);
    checkOutput("req_redirect_addr", 32'(imemAddr), 32'h10);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h0000_0001);
    checkOutput("req_drop_addr",  32'(imemAddr), 32'h3FF);
    checkOutput("req_drop_valid", 32'(ifValid),  32'd0);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h3FF);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h3FF);
    checkOutput("wrap_instr", instruc,        32'h3FF);
    checkOutput("wrap_pc",    32'(currentPc), 32'd0);
    checkOutput("wrap_addr",  32'(imemAddr),  32'd0);

    // Branch under stall is ignored; delivery resumes sequentially
    applyStimulus(1, 1, 0, 10'h080, '0, 0, 32'd0);
    checkOutput("stbr_instr", instruc,      32'h3FF);
    checkOutput("stbr_valid", 32'(ifValid), 32'd1);
    applyStimulus(1, 1, 0, 10'h080, '0, 0, 32'd0);
    checkOutput("stbr_addr",  32'(imemAddr), 32'd0);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h77);
    checkOutput("stbr_deliver_instr", instruc,        32'h77);
    checkOutput("stbr_deliver_pc",    32'(currentPc), 32'd1);
    checkOutput("stbr_deliver_addr",  32'(imemAddr),  32'd1);
`ifdef IF_FETCH_COUNT_EN
    checkOutput("count_run", fetchCount, 32'd7);
`endif

    // Reset in the middle of a fetch
    applyStimulus(0, 0, 0, '0, '0, 0, 32'd0);
    checkOutput("mid_req", 32'(imemReq), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_req",   32'(imemReq),   32'd0);
    checkOutput("mid_rst_addr",  32'(imemAddr),  32'd0);
    checkOutput("mid_rst_instr", instruc,        NOP);
    checkOutput("mid_rst_valid", 32'(ifValid),   32'd0);
    checkOutput("mid_rst_pc",    32'(currentPc), 32'd0);
`ifdef IF_FETCH_COUNT_EN
    checkOutput("mid_rst_count", fetchCount, 32'd0);
`endif
    imemReady = 1'b1;
    imemData  = 32'h55;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h55);
    checkOutput("post_rst_idle_valid", 32'(ifValid), 32'd0);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h55);
    applyStimulus(0, 0, 0, '0, '0, 1, 32'h55);
    checkOutput("post_rst_instr", instruc,        32'h55);
    checkOutput("post_rst_pc",    32'(currentPc), 32'd1);
    checkOutput("post_rst_valid", 32'(ifValid),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
